lobo_mult_pipe: RTL and testbench
=================================

Name: lobo_mult_pipe

Overview:
- Parametrised, pipelined successor to the 16-bit combinational hybrid approximate multiplier.
- Splits signed operand x into one exact radix-4 Booth digit (top three bits) and a low part. The low part is multiplied approximately with a leading-one (logarithmic) decomposition, quantised by QX/QY.
- Adds a 3-stage valid/ready pipeline with backpressure and a per-operation exact/approximate mode select.
- Sits between an operand stream source and an accumulator/consumer.

Parameters:
- W, 16, operand width for x and y, signed two's complement; legal range 8..32.
- QX, 8, lowest leading-one position of the x low part that is honoured; range 1..W-3.
- QY, 4, number of top magnitude bits of y (positions W-2 down to W-1-QY) searched for the y leading one; range 1..W-2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts the pair this cycle.
- in_x  in  W  signed multiplier.
- in_y  in  W  signed multiplicand.
- in_exact  in  1  1 = exact product, 0 = approximate.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_p  out  2W  signed product.
- busy  out  1  at least one pipeline stage holds a valid operation.

Behaviour:
- Reset: clears all stage valid bits. out_valid=0, out_p=0, busy=0, in_ready=1 in the cycle after rst is sampled high. A rst asserted mid-operation discards all in-flight operations; no result from them ever appears.
- Pipeline stages:
  - S1: capture the operands, Booth-encode the digit, compute magnitudes, run the leading-one detectors.
  - S2: form shifted partial terms and the upper partial product.
  - S3: final 2W-bit add, registered into out_p.
- Latency is exactly 3 cycles from the in_valid&in_ready edge to out_valid, with no stall.
- Handshake:
  - Each stage advances when it is empty or the next stage advances; S3 advances when out_valid=0 or out_ready=1.
  - in_ready = !S1.valid | S1 advances. A combinational path from out_ready to in_ready is permitted.
  - Throughput is 1 op/cycle when out_ready is held at 1.
  - While out_valid=1 and out_ready=0, out_p and out_valid hold stable.
  - Ordering is strictly FIFO; no op is dropped or duplicated.
- busy = OR of the S1..S3 valid bits.
- Exact mode: out_p = x*y, signed, full 2W bits.
- Approximate mode. Let n=W-2, L = x[n-1:0] as signed n-bit, a = L XOR {n{x[n-1]}}, b = y XOR {W{y[W-1]}}.
  - Digit: d = -2*x[W-1] + x[W-2] + x[W-3] (values -2..2). Upper term U = d*y*2^n, exact.
  - x leading one: px = position of the leading one of a. If a≠0 and px≥QX: T1 = b<<px and r = a with bit px cleared. Otherwise T1 = 0 and r = a.
  - y leading one: py = highest set bit of b within positions W-2..W-1-QY. If one exists, T2 = r<<py; else T2 = 0.
  - Low term: s = x[n-1] XOR y[W-1]; Plow = s ? -(T1+T2) : (T1+T2).
  - Result: out_p = (U + Plow) mod 2^(2W).
  - Note: a is a ones'-complement magnitude (no +1); this is intentional and matches the existing block's error profile.
- in_exact travels with its op. Mixed modes back-to-back are legal and each result uses its own mode.
- out_p keeps its last value when out_valid=0; the value is not otherwise specified after first use.

Test Plan (W=16, QX=8, QY=4):
- Reset then idle: out_valid=0, out_p=0, busy=0, in_ready=1.
- Approx x=0x0300, y=0x4000 -> out_p=0x00C00000, 3 cycles after accept.
- Approx x=0x4000, y=0x0003 -> 0x0000C000. Approx x=0xFF00, y=0x4000 -> 0xFFC04000 (ones'-complement error visible). Approx x=0x0005, y=0x0003 -> 0x00000000.
- Exact x=0xFFFD, y=0x0007 -> 0xFFFFFFEB. Exact and approx ops issued alternately in consecutive cycles each match their own model.
- Stream 8 ops with out_ready=0 for cycles 4..9:
  - in_ready drops once S1..S3 are full.
  - out_p stays stable while stalled.
  - All 8 results arrive in order; no loss or duplication.
- Assert rst for one cycle with 3 ops in flight: no stale out_valid afterwards; the next op returns a correct result at latency 3.

Source files
------------

// File: rtl/lobo_mult_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lobo_mult_pipe                                                             |
// | 3-stage valid/ready hybrid multiplier: one exact radix-4 Booth digit plus  |
// | a leading-one approximate low part, with per-operation exact mode.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lobo_mult_pipe #(
   parameter int W  = 16,
   parameter int QX = 8,
   parameter int QY = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_x,
   input  logic [W-1:0]     in_y,
   input  logic             in_exact,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   out_p,
   output logic             busy
);

   localparam int c_N  = W - 2;
   localparam int c_PW = $clog2(W);
   localparam logic [c_N-1:0] c_ONE = {{(c_N-1){1'b0}}, 1'b1};

   // ------------------------------------------------------------------------
   // Handshake: a stage advances when it is empty or its successor advances
   // ------------------------------------------------------------------------
   logic r_v1, r_v2, r_v3;
   logic w_adv1, w_adv2, w_adv3, w_take;

   assign w_adv3    = !r_v3 || out_ready;
   assign w_adv2    = !r_v2 || w_adv3;
   assign w_adv1    = !r_v1 || w_adv2;
   assign w_take    = in_valid && w_adv1;
   assign in_ready  = w_adv1;
   assign out_valid = r_v3;
   assign busy      = r_v1 | r_v2 | r_v3;

   // ------------------------------------------------------------------------
   // Stage 1 logic: Booth digit, ones'-complement magnitudes, leading ones
   // ------------------------------------------------------------------------
   logic [c_N-1:0]  w_a;
   logic [W-1:0]    w_b;
   logic [c_PW-1:0] w_px, w_py;
   logic            w_px_hit, w_py_hit;
   logic            w_one, w_two, w_neg;

   assign w_one = in_x[W-2] ^ in_x[W-3];
   assign w_two = (in_x[W-1] & ~in_x[W-2] & ~in_x[W-3]) |
                  (~in_x[W-1] & in_x[W-2] & in_x[W-3]);
   assign w_neg = in_x[W-1] & ~(in_x[W-2] & in_x[W-3]);

   // Later iterations overwrite earlier ones, so the highest set bit wins.
   always_comb begin
      w_a      = in_x[c_N-1:0] ^ {c_N{in_x[c_N-1]}};
      w_b      = in_y ^ {W{in_y[W-1]}};
      w_px     = '0;
      w_px_hit = 1'b0;
      for (int i = 0; i < c_N; i++) begin
         if (w_a[i]) begin
            w_px     = c_PW'(i);
            w_px_hit = (i >= QX);
         end
      end
      w_py     = '0;
      w_py_hit = 1'b0;
      for (int i = W - 1 - QY; i <= W - 2; i++) begin
         if (w_b[i]) begin
            w_py     = c_PW'(i);
            w_py_hit = 1'b1;
         end
      end
   end

   logic [W-1:0]    r1_x, r1_y, r1_b;
   logic [c_N-1:0]  r1_a;
   logic [c_PW-1:0] r1_px, r1_py;
   logic            r1_px_hit, r1_py_hit;
   logic            r1_one, r1_two, r1_neg, r1_s, r1_exact;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1 <= 1'b0;
      end else if (w_adv1) begin
         r_v1 <= in_valid;
      end
      if (w_take) begin
         r1_x      <= in_x;
         r1_y      <= in_y;
         r1_a      <= w_a;
         r1_b      <= w_b;
         r1_px     <= w_px;
         r1_px_hit <= w_px_hit;
         r1_py     <= w_py;
         r1_py_hit <= w_py_hit;
         r1_one    <= w_one;
         r1_two    <= w_two;
         r1_neg    <= w_neg;
         r1_s      <= in_x[c_N-1] ^ in_y[W-1];
         r1_exact  <= in_exact;
      end
   end

   // ------------------------------------------------------------------------
   // Stage 2 logic: upper Booth term, shifted low terms, exact product
   // ------------------------------------------------------------------------
   logic [2*W-1:0] w_yext, w_ymag, w_u, w_t1, w_t2, w_prod;
   logic [c_N-1:0] w_r;

   assign w_yext = {{W{r1_y[W-1]}}, r1_y};
   assign w_ymag = r1_two ? (w_yext << 1) : (r1_one ? w_yext : '0);
   assign w_u    = (r1_neg ? -w_ymag : w_ymag) << c_N;
   assign w_t1   = r1_px_hit ? ({{W{1'b0}}, r1_b} << r1_px) : '0;
   assign w_r    = r1_px_hit ? (r1_a & ~(c_ONE << r1_px)) : r1_a;
   assign w_t2   = r1_py_hit ? ({{(W+2){1'b0}}, w_r} << r1_py) : '0;
   // Sign-extended operands make the truncated unsigned product equal x*y.
   assign w_prod = {{W{r1_x[W-1]}}, r1_x} * w_yext;

   // Exact ops reuse the stage-3 adder with zeroed low terms.
   logic [2*W-1:0] r2_u, r2_t1, r2_t2;
   logic           r2_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v2 <= 1'b0;
      end else if (w_adv2) begin
         r_v2 <= r_v1;
      end
      if (w_adv2 && r_v1) begin
         r2_u  <= r1_exact ? w_prod : w_u;
         r2_t1 <= r1_exact ? '0 : w_t1;
         r2_t2 <= r1_exact ? '0 : w_t2;
         r2_s  <= r1_exact ? 1'b0 : r1_s;
      end
   end

   // ------------------------------------------------------------------------
   // Stage 3: signed low term and final 2W-bit sum
   // ------------------------------------------------------------------------
   logic [2*W-1:0] w_sum, w_low, w_res;
   logic [2*W-1:0] r_p;

   assign w_sum = r2_t1 + r2_t2;
   assign w_low = r2_s ? -w_sum : w_sum;
   assign w_res = r2_u + w_low;
   assign out_p = r_p;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v3 <= 1'b0;
         r_p  <= '0;
      end else if (w_adv3) begin
         r_v3 <= r_v2;
         if (r_v2) begin
            r_p <= w_res;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lobo_mult_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lobo_mult_pipe                                                          |
// | Scoreboard bench for lobo_mult_pipe at W=16, QX=8, QY=4.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lobo_mult_pipe;

   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst, in_valid, in_ready, in_exact, out_valid, out_ready, busy;
   logic [W-1:0]   in_x, in_y;
   logic [2*W-1:0] out_p;

   int             n_run  = 0;
   int             n_fail = 0;
   logic [2*W-1:0] exp_q[$];

   always #5 clk = ~clk;

   lobo_mult_pipe #(.W(16), .QX(8), .QY(4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_exact  (in_exact),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .busy      (busy)
   );

   // Reference product written straight from the arithmetic definition.
   function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input logic ex);
      longint      u, t1, t2, low, sum;
      logic [13:0] a, r;
      logic [15:0] b;
      logic [63:0] tot;
      int          d, px, py;
      if (ex) begin
         tot = 64'(longint'($signed(x)) * longint'($signed(y)));
         return tot[31:0];
      end
      d = 0;
      if (x[14]) d++;
      if (x[13]) d++;
      if (x[15]) d -= 2;
      u  = longint'(d) * longint'($signed(y)) * 64'sd16384;
      a  = x[13:0] ^ {14{x[13]}};
      b  = y ^ {16{y[15]}};
      r  = a;
      t1 = 0;
      px = -1;
      for (int i = 13; i >= 0; i--) if (a[i] && px < 0) px = i;
      if (px >= 8) begin
         t1    = longint'({48'd0, b}) << px;
         r[px] = 1'b0;
      end
      py = -1;
      for (int i = 14; i >= 11; i--) if (b[i] && py < 0) py = i;
      t2  = (py >= 0) ? (longint'({50'd0, r}) << py) : 64'sd0;
      sum = t1 + t2;
      low = (x[13] ^ y[15]) ? -sum : sum;
      tot = 64'(u + low);
      return tot[31:0];
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_exact = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_run++; if (out_p !== 32'h0) begin n_fail++; $display("FAIL reset_out_p: got %h want 00000000", out_p); end
      n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_approx();
      logic [63:0] vec[4];
      logic [31:0] e;
      int          lat;
      vec = '{64'h0300_4000_00C0_0000, 64'h4000_0003_0000_C000,
              64'hFF00_4000_FFC0_4000, 64'h0005_0003_0000_0000};
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         in_x = vec[i][63:48]; in_y = vec[i][47:32]; in_exact = 1'b0; in_valid = 1'b1;
         exp_q.push_back(vec[i][31:0]);
         @(posedge clk); #1;
         in_valid = 1'b0;
         lat = 1;
         while (out_valid !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
         e = exp_q.pop_front();
         n_run++; if (lat != 3) begin n_fail++; $display("FAIL approx_latency[%0d]: got %0d want 3", i, lat); end
         n_run++; if (out_p !== e) begin n_fail++; $display("FAIL approx_result[%0d]: got %h want %h", i, out_p, e); end
      end
   endtask

   task automatic test_exact();
      logic [63:0] vec[2];
      logic [31:0] e;
      int          lat;
      vec = '{64'hFFFD_0007_FFFF_FFEB, 64'h8000_8000_4000_0000};
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         in_x = vec[i][63:48]; in_y = vec[i][47:32]; in_exact = 1'b1; in_valid = 1'b1;
         exp_q.push_back(vec[i][31:0]);
         @(posedge clk); #1;
         in_valid = 1'b0;
         lat = 1;
         while (out_valid !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
         e = exp_q.pop_front();
         n_run++; if (lat != 3) begin n_fail++; $display("FAIL exact_latency[%0d]: got %0d want 3", i, lat); end
         n_run++; if (out_p !== e) begin n_fail++; $display("FAIL exact_result[%0d]: got %h want %h", i, out_p, e); end
      end
   endtask

   // Alternating exact/approx ops issued on every cycle with the sink always ready.
   task automatic test_back_to_back();
      logic [15:0] xs[8], ys[8];
      logic [31:0] e;
      int          sent, got, cyc;
      for (int i = 0; i < 8; i++) begin xs[i] = 16'($urandom); ys[i] = 16'($urandom); end
      xs[0] = 16'h0300; ys[0] = 16'h4000;
      sent = 0; got = 0; cyc = 0; out_ready = 1'b1;
      @(posedge clk); #1;
      while ((sent < 8 || got < 8) && cyc < 50) begin
         if (sent < 8) begin
            in_x = xs[sent]; in_y = ys[sent]; in_exact = sent[0]; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (sent < 8) begin
            n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", cyc, in_ready); end
         end
         if (in_valid && in_ready) begin exp_q.push_back(model(in_x, in_y, in_exact)); sent++; end
         if (out_valid === 1'b1 && out_ready) begin
            n_run++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL b2b_spurious: got %h want no result", out_p);
            end else begin
               e = exp_q.pop_front();
               if (out_p !== e) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h want %h", got, out_p, e); end
            end
            got++;
         end
         @(posedge clk); #1; cyc++;
      end
      in_valid = 1'b0;
      n_run++; if (got != 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", got); end
   endtask

   // Eight ops streamed while the sink stalls for cycles 4..9.
   task automatic test_stall_stream();
      logic [15:0] xs[8], ys[8];
      logic [31:0] e, held_p;
      logic        held_v, saw_block;
      int          sent, got, cyc;
      for (int i = 0; i < 8; i++) begin xs[i] = 16'($urandom); ys[i] = 16'($urandom); end
      sent = 0; got = 0; cyc = 0; held_v = 1'b0; held_p = '0; saw_block = 1'b0;
      @(posedge clk); #1;
      while ((sent < 8 || got < 8) && cyc < 60) begin
         out_ready = !(cyc >= 4 && cyc <= 9);
         if (sent < 8) begin
            in_x = xs[sent]; in_y = ys[sent]; in_exact = (sent % 3 == 0); in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (held_v) begin
            n_run++;
            if (out_valid !== 1'b1 || out_p !== held_p) begin
               n_fail++; $display("FAIL stall_hold[%0d]: got v=%b p=%h want v=1 p=%h", cyc, out_valid, out_p, held_p);
            end
         end
         held_v = (out_valid === 1'b1) && !out_ready;
         held_p = out_p;
         if (in_valid && !in_ready) saw_block = 1'b1;
         if (in_valid && in_ready) begin exp_q.push_back(model(in_x, in_y, in_exact)); sent++; end
         if (out_valid === 1'b1 && out_ready) begin
            n_run++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL stall_spurious: got %h want no result", out_p);
            end else begin
               e = exp_q.pop_front();
               if (out_p !== e) begin n_fail++; $display("FAIL stall_result[%0d]: got %h want %h", got, out_p, e); end
            end
            got++;
         end
         @(posedge clk); #1; cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_run++; if (saw_block !== 1'b1) begin n_fail++; $display("FAIL stall_backpressure: got in_ready never low want low"); end
      n_run++; if (got != 8) begin n_fail++; $display("FAIL stall_count: got %0d want 8", got); end
      n_run++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_leftover: got %0d queued want 0", exp_q.size()); end
   endtask

   task automatic test_reset_midflight();
      logic [31:0] e;
      int          lat;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_x = 16'h1234 + 16'(i); in_y = 16'h0F0F; in_exact = 1'b1; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
      n_run++; if (out_p !== 32'h0) begin n_fail++; $display("FAIL midrst_out_p: got %h want 00000000", out_p); end
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale[%0d]: got %b want 0", i, out_valid); end
         @(posedge clk); #1;
      end
      in_x = 16'hFF00; in_y = 16'h4000; in_exact = 1'b0; in_valid = 1'b1;
      exp_q.push_back(32'hFFC0_4000);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
      e = exp_q.pop_front();
      n_run++; if (lat != 3) begin n_fail++; $display("FAIL midrst_latency: got %0d want 3", lat); end
      n_run++; if (out_p !== e) begin n_fail++; $display("FAIL midrst_result: got %h want %h", out_p, e); end
   endtask

   initial begin
      test_reset();
      test_approx();
      test_exact();
      test_back_to_back();
      test_stall_stream();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
